// File: rtl/mips_pkg.sv
// Shared decode constants, ALU operation enum and the control bundle for mips_core.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU= 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     alu_imm;
    logic     imm_zext;
    logic     reg_write;
    dst_sel_e dst;
    logic     mem_read;
    logic     mem_write;
    logic     beq;
    logic     bne;
    logic     jump;
    logic     link;
    logic     jr;
  } ctrl_t;
endpackage

// File: rtl/mips_core_if.sv
// Data-memory bus between the core datapath (master) and the data memory (slave).
interface mips_core_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU; zero flag drives beq/bne.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      ALU_SLLV: result = b << a[4:0];
      ALU_SRLV: result = b >> a[4:0];
      ALU_LUI:  result = {b[15:0], 16'b0};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/mips_control.sv
// Opcode/funct decoder; anything unrecognised decodes to an all-zero (NOP) bundle.
module mips_control
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_SRA:          ctrl.alu_op = ALU_SRA;
          FN_SLLV:         ctrl.alu_op = ALU_SLLV;
          FN_SRLV:         ctrl.alu_op = ALU_SRLV;
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_JR: begin
            ctrl.reg_write = 1'b0;
            ctrl.jr        = 1'b1;
          end
          default:         ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dst       = DST_RT;
        ctrl.imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        case (opcode)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_XORI: ctrl.alu_op = ALU_XOR;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dst       = DST_RT;
        ctrl.mem_read  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.beq    = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.bne    = 1'b1;
      end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dst       = DST_RA;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_core_state.sv
// State-holding units of mips_core: PC, instruction memory, register file, data memory.
module mips_pc #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next,
  output logic [31:0] OUT
);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) OUT <= '0;
    else        OUT <= next & PC_MASK;
endmodule

module mips_imem #(
  parameter int WORDS = 256
) (
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(WORDS);

  // Contents are loaded from outside through hierarchy; no write port.
  logic [31:0] InstructionMemory [0:WORDS-1];
  logic        unused_addr;

  assign rdata       = InstructionMemory[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] Registers [0:31];

  assign rd1 = (ra1 == '0) ? '0 : Registers[ra1];
  assign rd2 = (ra2 == '0) ? '0 : Registers[ra2];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (we && wa != '0) begin
      Registers[wa] <= wd;
    end
endmodule

module mips_dmem #(
  parameter int WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_core_if.slave    bus
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] mem [0:WORDS-1];
  logic        unused_addr;

  assign bus.rdata   = mem[bus.addr[AW+1:2]];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // Not reset, but a store coinciding with reset is dropped.
  always_ff @(posedge clk)
    if (bus.we && rst_n) mem[bus.addr[AW+1:2]] <= bus.wdata;
endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS-I subset CPU: one instruction retires per rising clk edge.
module mips_core
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic rst_n
);
  logic [31:0] pc, pc4, pc_next, instr;
  logic [31:0] rs_val, rt_val, imm_sx, imm_ext, alu_b, alu_res, wb_data, br_target;
  logic [4:0]  dst;
  logic        zero, take_br;
  ctrl_t       ctrl;

  mips_core_if dbus ();

  mips_pc #(.IMEM_WORDS(IMEM_WORDS)) ProgCounter (
    .clk, .rst_n, .next(pc_next), .OUT(pc)
  );

  mips_imem #(.WORDS(IMEM_WORDS)) IM (.addr(pc), .rdata(instr));

  mips_control ctl (.opcode(instr[31:26]), .funct(instr[5:0]), .ctrl);

  mips_regfile RF (
    .clk, .rst_n,
    .ra1(instr[25:21]), .ra2(instr[20:16]), .rd1(rs_val), .rd2(rt_val),
    .we(ctrl.reg_write), .wa(dst), .wd(wb_data)
  );

  assign imm_sx  = {{16{instr[15]}}, instr[15:0]};
  assign imm_ext = ctrl.imm_zext ? {16'b0, instr[15:0]} : imm_sx;
  assign alu_b   = ctrl.alu_imm ? imm_ext : rt_val;

  mips_alu alu (
    .a(rs_val), .b(alu_b), .shamt(instr[10:6]), .op(ctrl.alu_op), .result(alu_res), .zero
  );

  assign dbus.addr  = alu_res;
  assign dbus.wdata = rt_val;
  assign dbus.we    = ctrl.mem_write;

  mips_dmem #(.WORDS(DMEM_WORDS)) DM (.clk, .rst_n, .bus(dbus.slave));

  always_comb begin
    case (ctrl.dst)
      DST_RT:  dst = instr[20:16];
      DST_RA:  dst = RA;
      default: dst = instr[15:11];
    endcase
  end

  assign pc4     = pc + 32'd4;
  assign wb_data = ctrl.link ? pc4 : (ctrl.mem_read ? dbus.rdata : alu_res);

  // Branch compare reuses the ALU subtract: zero means rs == rt.
  assign br_target = pc4 + {imm_sx[29:0], 2'b00};
  assign take_br   = (ctrl.beq & zero) | (ctrl.bne & ~zero);

  always_comb begin
    pc_next = pc4;
    if (ctrl.jr)        pc_next = rs_val;
    else if (ctrl.jump) pc_next = {pc4[31:28], instr[25:0], 2'b00};
    else if (take_br)   pc_next = br_target;
  end
endmodule

// File: tb/tb_mips_core.sv
// Directed programs plus random programs, checked per cycle against an instruction-level model.
module tb_mips_core;
  logic clk, rst_n;
  int   total, bad;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] prog [$];

  mips_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .rst_n(rst_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int addr);
    return {6'(op), 26'(addr)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  // Instruction-set interpreter: one architectural step per call.
  task automatic model_step();
    logic [31:0] ins, rsv, rtv, sx, zx, nx, ea, sr;
    logic [4:0]  rs, rt, rd, sh;
    ins = m_imem[(m_pc / 4) % 256];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    rsv = m_regs[rs]; rtv = m_regs[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'b0, ins[15:0]};
    ea = rsv + sx;
    nx = m_pc + 4;
    case (int'(ins[31:26]))
      0: case (int'(ins[5:0]))
           'h00: wr(rd, rtv << sh);
           'h02: wr(rd, rtv >> sh);
           'h03: begin sr = $signed(rtv) >>> sh; wr(rd, sr); end
           'h04: wr(rd, rtv << rsv[4:0]);
           'h06: wr(rd, rtv >> rsv[4:0]);
           'h08: nx = rsv;
           'h20, 'h21: wr(rd, rsv + rtv);
           'h22, 'h23: wr(rd, rsv - rtv);
           'h24: wr(rd, rsv & rtv);
           'h25: wr(rd, rsv | rtv);
           'h26: wr(rd, rsv ^ rtv);
           'h27: wr(rd, ~(rsv | rtv));
           'h2A: wr(rd, ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0);
           'h2B: wr(rd, (rsv < rtv) ? 32'd1 : 32'd0);
           default: ;
         endcase
      2: nx = {nx[31:28], ins[25:0], 2'b00};
      3: begin wr(5'd31, m_pc + 4); nx = {nx[31:28], ins[25:0], 2'b00}; end
      4: if (rsv == rtv) nx = m_pc + 4 + (sx << 2);
      5: if (rsv != rtv) nx = m_pc + 4 + (sx << 2);
      8, 9: wr(rt, rsv + sx);
      10: wr(rt, ($signed(rsv) < $signed(sx)) ? 32'd1 : 32'd0);
      12: wr(rt, rsv & zx);
      13: wr(rt, rsv | zx);
      14: wr(rt, rsv ^ zx);
      15: wr(rt, {ins[15:0], 16'b0});
      'h23: wr(rt, m_dmem[(ea / 4) % 256]);
      'h2B: m_dmem[(ea / 4) % 256] = rtv;
      default: ;
    endcase
    m_pc = nx % 1024;
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, dut.ProgCounter.OUT, m_pc);
    for (int i = 0; i < 32; i++) chk($sformatf("%s.r%0d", tag, i), dut.RF.Registers[i], m_regs[i]);
  endtask

  // Hold reset, load the queued program into IM and the model, then release.
  task automatic start(input string tag);
    logic [31:0] w;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'd0;
      dut.IM.InstructionMemory[i] = w;
      m_imem[i] = w;
    end
    model_reset();
    #1;
    chk({tag, ".rst.pc"}, dut.ProgCounter.OUT, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("%s.rst.r%0d", tag, i), dut.RF.Registers[i], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prog.delete();
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      chk_state(tag);
    end
  endtask

  function automatic int rreg();
    int s = int'($urandom_range(0, 9));
    if (s == 0) return 0;
    if (s == 1) return 31;
    return 8 + int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr();
    int fl [15] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int il [7]  = '{8, 9, 10, 12, 13, 14, 15};
    int off;
    case (int'($urandom_range(0, 11)))
      0, 1, 2, 3: return enc_r(fl[$urandom_range(0, 14)], rreg(), rreg(), rreg(), int'($urandom_range(0, 31)));
      4, 5: return enc_i(il[$urandom_range(0, 6)], rreg(), rreg(), int'($urandom_range(0, 65535)));
      6: return enc_i($urandom_range(0, 1) ? 'h23 : 'h2B, 0, rreg(), 4 * int'($urandom_range(0, 15)));
      7: begin
        off = int'($urandom_range(0, 12)) - 6;
        if (off == -1) off = 3;
        return enc_i(4 + int'($urandom_range(0, 1)), rreg(), rreg(), off);
      end
      8: return enc_j(2 + int'($urandom_range(0, 1)), int'($urandom));
      9: return enc_r($urandom_range(0, 1) ? 'h08 : int'($urandom_range(44, 63)), rreg(), rreg(), rreg(), 0);
      10: return enc_i(int'($urandom_range(16, 31)), rreg(), rreg(), int'($urandom_range(0, 65535)));
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;

    // Reset and start: empty IM runs through NOPs
    start("boot");
    run("boot", 10);
    chk("boot.pc28", dut.ProgCounter.OUT, 32'h28);
    prog.push_back(enc_i(8, 0, 0, 5));
    start("zero");
    run("zero", 2);
    chk("zero.r0", dut.RF.Registers[0], 32'd0);

    // ALU and immediates
    prog.push_back(enc_i(15, 0, 8, 'h1234));
    prog.push_back(enc_i(13, 8, 8, 'h5678));
    prog.push_back(enc_i(8, 0, 9, -1));
    prog.push_back(enc_r('h00, 0, 8, 10, 8));
    prog.push_back(enc_r('h02, 0, 9, 11, 28));
    prog.push_back(enc_r('h2A, 9, 0, 12, 0));
    prog.push_back(enc_r('h2B, 9, 0, 13, 0));
    start("alu");
    run("alu", 7);
    chk("alu.t0", dut.RF.Registers[8],  32'h12345678);
    chk("alu.t1", dut.RF.Registers[9],  32'hFFFFFFFF);
    chk("alu.t2", dut.RF.Registers[10], 32'h34567800);
    chk("alu.t3", dut.RF.Registers[11], 32'h0000000F);
    chk("alu.t4", dut.RF.Registers[12], 32'd1);
    chk("alu.t5", dut.RF.Registers[13], 32'd0);

    // Asynchronous reset pulse between edges clears PC and registers at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset.pc", dut.ProgCounter.OUT, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("areset.r%0d", i), dut.RF.Registers[i], 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    run("restart", 2);

    // Memory
    prog.push_back(enc_i(8, 0, 8, 'h55));
    prog.push_back(enc_i('h2B, 0, 8, 8));
    prog.push_back(enc_i('h23, 0, 9, 8));
    prog.push_back(enc_i(8, 0, 8, 'h66));
    prog.push_back(enc_i('h2B, 0, 8, 4));
    prog.push_back(enc_i('h23, 0, 10, 4));
    start("mem");
    run("mem", 6);
    chk("mem.t1", dut.RF.Registers[9],  32'h55);
    chk("mem.t2", dut.RF.Registers[10], 32'h66);

    // Branch countdown loop; reset must leave data memory intact
    prog.push_back(enc_i(8, 0, 8, 3));
    prog.push_back(enc_i(8, 8, 8, -1));
    prog.push_back(enc_i(5, 8, 0, -2));
    prog.push_back(enc_i(8, 0, 9, 7));
    start("bne");
    chk("keep.w2", dut.DM.mem[2], 32'h55);
    chk("keep.w1", dut.DM.mem[1], 32'h66);
    run("bne", 8);
    chk("bne.t0", dut.RF.Registers[8], 32'd0);
    chk("bne.t1", dut.RF.Registers[9], 32'd7);
    chk("bne.pc", dut.ProgCounter.OUT, 32'h10);

    prog.push_back(enc_i(8, 0, 8, 1));
    prog.push_back(enc_i(4, 8, 0, 3));
    prog.push_back(enc_i(8, 0, 9, 9));
    start("beq");
    run("beq", 3);
    chk("beq.t1", dut.RF.Registers[9], 32'd9);
    chk("beq.pc", dut.ProgCounter.OUT, 32'hC);

    // Jumps: jal 0x20, jr $ra back to 0x4, j 0x40
    prog.push_back(enc_j(3, 8));
    prog.push_back(enc_j(2, 16));
    for (int i = 0; i < 6; i++) prog.push_back(32'd0);
    prog.push_back(enc_r('h08, 31, 0, 0, 0));
    start("jmp");
    run("jal", 1);
    chk("jal.pc", dut.ProgCounter.OUT, 32'h20);
    chk("jal.ra", dut.RF.Registers[31], 32'h4);
    run("jr", 1);
    chk("jr.pc", dut.ProgCounter.OUT, 32'h4);
    run("j", 1);
    chk("j.pc", dut.ProgCounter.OUT, 32'h40);

    // Reset held across an edge aborts the store in flight
    prog.push_back(enc_i(8, 0, 8, 'h11));
    prog.push_back(enc_i('h2B, 0, 8, 12));
    prog.push_back(enc_i(8, 0, 8, 'h77));
    prog.push_back(enc_i('h2B, 0, 8, 12));
    start("abort");
    run("abort", 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.w3", dut.DM.mem[3], 32'h11);
    chk("abort.t0", dut.RF.Registers[8], 32'd0);
    chk("abort.pc", dut.ProgCounter.OUT, 32'd0);
    m_dmem[3] = 32'h11;

    // PC wraps modulo 1024 bytes
    start("wrap");
    run("wrap", 260);
    chk("wrap.pc", dut.ProgCounter.OUT, 32'h10);

    // Random programs: a prologue defines data words 0..15, then random code
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 16; w++) begin
        prog.push_back(enc_i(8, 0, 8, int'($urandom_range(0, 65535))));
        prog.push_back(enc_i('h2B, 0, 8, 4 * w));
      end
      while (prog.size() < 256) prog.push_back(rnd_instr());
      start($sformatf("rnd%0d", p));
      run($sformatf("rnd%0d", p), 300);
      for (int w = 0; w < 16; w++) chk($sformatf("rnd%0d.dm%0d", p, w), dut.DM.mem[w], m_dmem[w]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
